// File: rtl/weight_mem_arbiter_if.sv
// Bundle between the inference/learning requesters, the arbiter and the
// single-port weight memory.
interface weight_mem_arbiter_if #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 8
);
    logic          inf_req;
    logic [AW-1:0] inf_addr;
    logic          inf_gnt;
    logic          inf_rvalid;
    logic [DW-1:0] inf_rdata;
    logic          lrn_en;
    logic          lrn_req;
    logic [AW-1:0] lrn_addr;
    logic [DW-1:0] lrn_delta;
    logic          lrn_gnt;
    logic          lrn_done;
    logic          lrn_sat;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  inf_req, inf_addr, lrn_en, lrn_req, lrn_addr, lrn_delta, mem_rdata,
        output inf_gnt, inf_rvalid, inf_rdata, lrn_gnt, lrn_done, lrn_sat, busy,
               mem_addr, mem_we, mem_wdata
    );

    modport master (
        output inf_req, inf_addr, lrn_en, lrn_req, lrn_addr, lrn_delta, mem_rdata,
        input  inf_gnt, inf_rvalid, inf_rdata, lrn_gnt, lrn_done, lrn_sat, busy,
               mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/weight_mem_arbiter.sv
// Shares the single-port weight memory between inference reads (priority)
// and atomic saturating read-modify-write learning updates.
module weight_mem_arbiter #(
    parameter int unsigned AW           = 4,
    parameter int unsigned DW           = 8,
    parameter int unsigned WMIN         = 0,
    parameter int unsigned WMAX         = 255,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    weight_mem_arbiter_if.slave bus
);
    localparam int unsigned SW = DW + 2;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0]        CNT_MAX = '1;
    localparam logic signed [SW-1:0] W_LO    = SW'(WMIN);
    localparam logic signed [SW-1:0] W_HI    = SW'(WMAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LRN_RD = 2'd1,
        LRN_WR = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        starve_q, starve_d;
    logic                 rvalid_q;
    logic [AW-1:0]        addr_q;
    logic [DW-1:0]        delta_q;
    logic [DW-1:0]        new_w_q, new_w_d;
    logic                 sat_q, sat_d;
    logic signed [SW-1:0] sum_c;

    logic          learn_wins_c;
    logic          inf_gnt_c;
    logic          lrn_gnt_c;
    logic          lrn_done_c;
    logic          lrn_sat_c;
    logic          busy_c;
    logic [AW-1:0] mem_addr_c;
    logic          mem_we_c;
    logic [DW-1:0] mem_wdata_c;

    assign learn_wins_c = bus.lrn_en & bus.lrn_req &
                          (~bus.inf_req | (starve_q >= CW'(STARVE_LIMIT)));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (learn_wins_c) state_d = LRN_RD;
            LRN_RD:  state_d = LRN_WR;
            LRN_WR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic; everything is forced low while reset is held
    always_comb begin
        inf_gnt_c   = 1'b0;
        lrn_gnt_c   = 1'b0;
        lrn_done_c  = 1'b0;
        lrn_sat_c   = 1'b0;
        busy_c      = 1'b0;
        mem_addr_c  = '0;
        mem_we_c    = 1'b0;
        mem_wdata_c = '0;
        case (state_q)
            IDLE: begin
                if (learn_wins_c) begin
                    lrn_gnt_c  = 1'b1;
                    mem_addr_c = bus.lrn_addr;
                end else if (bus.inf_req) begin
                    inf_gnt_c  = 1'b1;
                    mem_addr_c = bus.inf_addr;
                end
            end
            LRN_RD: begin
                busy_c     = 1'b1;
                mem_addr_c = addr_q;
            end
            LRN_WR: begin
                busy_c      = 1'b1;
                mem_addr_c  = addr_q;
                mem_we_c    = 1'b1;
                mem_wdata_c = new_w_q;
                lrn_done_c  = 1'b1;
                lrn_sat_c   = sat_q;
            end
            default: ;
        endcase
        if (!rst_n) begin
            inf_gnt_c   = 1'b0;
            lrn_gnt_c   = 1'b0;
            lrn_done_c  = 1'b0;
            lrn_sat_c   = 1'b0;
            busy_c      = 1'b0;
            mem_addr_c  = '0;
            mem_we_c    = 1'b0;
            mem_wdata_c = '0;
        end
    end

    // Saturating update: unsigned old weight plus signed delta, two guard bits
    always_comb begin
        sum_c   = $signed({2'b00, bus.mem_rdata}) + $signed({{2{delta_q[DW-1]}}, delta_q});
        new_w_d = sum_c[DW-1:0];
        sat_d   = 1'b0;
        if (sum_c < W_LO) begin
            new_w_d = DW'(WMIN);
            sat_d   = 1'b1;
        end else if (sum_c > W_HI) begin
            new_w_d = DW'(WMAX);
            sat_d   = 1'b1;
        end
    end

    // Anti-starvation count of lost arbitrations while learning waits
    always_comb begin
        starve_d = starve_q;
        if (!bus.lrn_en || !bus.lrn_req || lrn_gnt_c) starve_d = '0;
        else if (inf_gnt_c && starve_q != CNT_MAX)   starve_d = starve_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q <= '0;
            rvalid_q <= 1'b0;
            addr_q   <= '0;
            delta_q  <= '0;
            new_w_q  <= '0;
            sat_q    <= 1'b0;
        end else begin
            starve_q <= starve_d;
            rvalid_q <= inf_gnt_c;
            if (lrn_gnt_c) begin
                addr_q  <= bus.lrn_addr;
                delta_q <= bus.lrn_delta;
            end
            if (state_q == LRN_RD) begin
                new_w_q <= new_w_d;
                sat_q   <= sat_d;
            end
        end
    end

    assign bus.inf_gnt    = inf_gnt_c;
    assign bus.inf_rvalid = rvalid_q & rst_n;
    assign bus.inf_rdata  = rst_n ? bus.mem_rdata : '0;
    assign bus.lrn_gnt    = lrn_gnt_c;
    assign bus.lrn_done   = lrn_done_c;
    assign bus.lrn_sat    = lrn_sat_c;
    assign bus.busy       = busy_c;
    assign bus.mem_addr   = mem_addr_c;
    assign bus.mem_we     = mem_we_c;
    assign bus.mem_wdata  = mem_wdata_c;

endmodule
